// File: rtl/wb_types_pkg.sv
// wb_types_pkg: shared register map, command codes, bit positions and FSM encodings
package wb_types_pkg;
  typedef enum logic [1:0] {
    REG_CSR  = 2'd0,
    REG_DPR  = 2'd1,
    REG_CMDR = 2'd2,
    REG_FSMR = 2'd3
  } reg_addr_e;
  typedef enum logic [2:0] {
    CMD_NOP0     = 3'b000,
    CMD_WRITE    = 3'b001,
    CMD_READ_ACK = 3'b010,
    CMD_READ_NAK = 3'b011,
    CMD_START    = 3'b100,
    CMD_STOP     = 3'b101,
    CMD_BAD6     = 3'b110,
    CMD_BAD7     = 3'b111
  } cmd_e;
  localparam int CSR_E = 7;
  localparam int CSR_IE = 6;
  localparam int CMDR_DON = 7;
  localparam int CMDR_NAK = 6;
  localparam int CMDR_AL = 5;
  localparam int CMDR_ERR = 4;
  typedef enum logic [3:0] {
    ACC_IDLE = 4'd0,
    ACC_WAIT = 4'd1,
    ACC_ACK  = 4'd2
  } acc_state_e;
  typedef enum logic [3:0] {
    CMD_IDLE = 4'd0,
    CMD_BUSY = 4'd1
  } cmd_state_e;
endpackage

// File: rtl/wb_resp_cmd_engine.sv
// wb_resp_cmd_engine: fixed-latency command FSM with loopback data, status bits and irq flag
module wb_resp_cmd_engine
  import wb_types_pkg::*;
#(
  parameter int CMD_LATENCY = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en,
  input  logic       ie,
  input  logic       kill,
  input  logic       irq_clr,
  input  logic       cmd_wr,
  input  logic [2:0] cmd,
  input  logic       stat_rd,
  input  logic [7:0] tx,
  output logic [7:0] rx,
  output logic [7:0] status,
  output logic [3:0] fsm,
  output logic       irq
);
  localparam int CW = $clog2(CMD_LATENCY + 1);
  cmd_state_e state;
  logic [CW-1:0] cnt;
  logic [2:0] last;
  logic [7:0] loop;
  logic held, don, nak, err, done;
  assign done = state == CMD_BUSY && cnt == CW'(1);
  assign status = {don, nak, 1'b0, err, 1'b0, last};
  assign fsm = state;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= CMD_IDLE;
      cnt <= '0;
      last <= 3'd0;
      loop <= 8'h00;
      rx <= 8'h00;
      held <= 1'b0;
      don <= 1'b1;
      nak <= 1'b0;
      err <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (kill) begin
        state <= CMD_IDLE;
        held <= 1'b0;
      end else if (cmd_wr && en && state == CMD_IDLE) begin
        state <= CMD_BUSY;
        cnt <= CW'(CMD_LATENCY);
        {don, nak, err} <= 3'b000;
        last <= cmd;
      end else if (state == CMD_BUSY) begin
        cnt <= cnt - 1'b1;
        if (done) begin
          state <= CMD_IDLE;
          case (last)
            CMD_START: begin held <= 1'b1; don <= 1'b1; end
            CMD_STOP: begin held <= 1'b0; don <= 1'b1; end
            CMD_WRITE: begin
              if (held) loop <= tx;
              don <= held;
              nak <= !held;
            end
            CMD_READ_ACK, CMD_READ_NAK: begin
              if (held) rx <= loop;
              don <= held;
              err <= !held;
            end
            default: err <= 1'b1;
          endcase
        end
      end
      // a completion beats the clearing status read on the same edge
      irq <= (kill || irq_clr) ? 1'b0 : (done && ie) ? 1'b1 : stat_rd ? 1'b0 : irq;
    end
  end
endmodule

// File: rtl/wb_resp_regfile.sv
// wb_resp_regfile: Wishbone slave register file with wait-state access FSM and command engine
module wb_resp_regfile
  import wb_types_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int WAIT_STATES = 0,
  parameter int CMD_LATENCY = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  irq_o
);
  acc_state_e acc;
  logic [3:0] wcnt, cmd_fsm;
  logic [7:0] tx, rx, status, rdata;
  logic e, ie, hold, req, go, wr, rd, csr_wr;
  assign req = cyc_i && stb_i;
  // go marks the edge where ack_o rises: commits and read capture happen here
  assign go = req && ((acc == ACC_IDLE && !hold && WAIT_STATES == 0) || (acc == ACC_WAIT && wcnt == 4'd0));
  assign wr = go && we_i;
  assign rd = go && !we_i;
  assign csr_wr = wr && adr_i == REG_CSR;
  assign rdata = adr_i == REG_CSR ? {e, ie, 6'd0} : adr_i == REG_DPR ? rx : adr_i == REG_CMDR ? status : {acc, cmd_fsm};
  wb_resp_cmd_engine #(.CMD_LATENCY(CMD_LATENCY)) u_cmd (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en     (e),
    .ie     (ie),
    .kill   (csr_wr && !dat_i[CSR_E]),
    .irq_clr(csr_wr && !dat_i[CSR_IE]),
    .cmd_wr (wr && adr_i == REG_CMDR),
    .cmd    (dat_i[2:0]),
    .stat_rd(rd && adr_i == REG_CMDR),
    .tx     (tx),
    .rx     (rx),
    .status (status),
    .fsm    (cmd_fsm),
    .irq    (irq_o)
  );
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc <= ACC_IDLE;
      wcnt <= 4'd0;
      hold <= 1'b0;
      ack_o <= 1'b0;
      dat_o <= '0;
      e <= 1'b0;
      ie <= 1'b0;
      tx <= 8'h00;
    end else begin
      ack_o <= go;
      dat_o <= rd ? rdata : '0;
      // strobe still high right after the ack belongs to the finished access
      hold <= acc == ACC_ACK && req;
      if (csr_wr) {e, ie} <= dat_i[CSR_E:CSR_IE];
      if (wr && adr_i == REG_DPR) tx <= dat_i;
      case (acc)
        ACC_IDLE: if (req && !hold) begin
          acc <= WAIT_STATES == 0 ? ACC_ACK : ACC_WAIT;
          wcnt <= 4'(WAIT_STATES - 1);
        end
        ACC_WAIT: begin
          acc <= !req ? ACC_IDLE : wcnt == 4'd0 ? ACC_ACK : ACC_WAIT;
          wcnt <= wcnt - 1'b1;
        end
        default: acc <= ACC_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_resp_regfile.sv
// tb_wb_resp_regfile: directed bus traffic against a transaction-level model of the responder
module tb_wb_resp_regfile;
  localparam int WS = 3, L = 5;
  logic clk_i = 0, rst_i = 0, cyc_i = 0, stb_i = 0, we_i = 0, ack_o, irq_o;
  logic [1:0] adr_i = 0;
  logic [7:0] dat_i = 0, dat_o, q;
  int vec = 0, bad = 0, cyc_n = 0;
  logic txn_live = 0, txn_we = 0;
  logic [1:0] txn_adr = 0;
  logic [7:0] txn_dat = 0;
  int txn_edge = 0, ack_edge = 0, irq_edge = 0, lat = 0;
  logic m_e, m_ie, m_held, m_busy, m_irq, m_don, m_nak, m_err;
  logic [7:0] m_tx, m_rx, m_loop, exp_d;
  logic [2:0] m_last;
  int m_done_at;
  logic commit, done, busy0;

  wb_resp_regfile #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .WAIT_STATES(WS), .CMD_LATENCY(L)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .dat_i(dat_i), .ack_o(ack_o), .dat_o(dat_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc_n <= cyc_n + 1;
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [1:0] a);
    // read of FSMR is captured while the access FSM still sits in WAIT when WS>0
    return a == 2'd0 ? {m_e, m_ie, 6'd0} : a == 2'd1 ? m_rx :
           a == 2'd2 ? {m_don, m_nak, 1'b0, m_err, 1'b0, m_last} : {4'(WS > 0), 3'd0, m_busy};
  endfunction

  task automatic m_reset;
    {m_e, m_ie, m_held, m_busy, m_irq, m_nak, m_err} = '0;
    m_don = 1;
    m_tx = 0; m_rx = 0; m_loop = 0; m_last = 0; m_done_at = 0;
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      m_reset();
      txn_live = 0;
      chk("rst ack", 8'(ack_o), 8'h00);
      chk("rst dat", dat_o, 8'h00);
      chk("rst irq", 8'(irq_o), 8'h00);
    end else begin
      commit = txn_live && txn_edge == cyc_n;
      busy0 = m_busy;
      done = m_busy && m_done_at == cyc_n;
      exp_d = (commit && !txn_we) ? m_read(txn_adr) : 8'h00;
      if (commit && !txn_we && txn_adr == 2'd2) m_irq = 0;
      if (done) begin
        m_busy = 0;
        case (m_last)
          3'b100: begin m_held = 1; m_don = 1; end
          3'b101: begin m_held = 0; m_don = 1; end
          3'b001: if (m_held) begin m_loop = m_tx; m_don = 1; end else m_nak = 1;
          3'b010, 3'b011: if (m_held) begin m_rx = m_loop; m_don = 1; end else m_err = 1;
          default: m_err = 1;
        endcase
        if (m_ie) m_irq = 1;
      end
      if (commit && txn_we) begin
        if (txn_adr == 2'd0) begin
          if (!txn_dat[7]) begin m_busy = 0; m_held = 0; m_irq = 0; end
          if (!txn_dat[6]) m_irq = 0;
          m_e = txn_dat[7];
          m_ie = txn_dat[6];
        end else if (txn_adr == 2'd1) m_tx = txn_dat;
        else if (txn_adr == 2'd2 && m_e && !busy0) begin
          m_busy = 1;
          m_done_at = cyc_n + L;
          {m_don, m_nak, m_err} = 0;
          m_last = txn_dat[2:0];
        end
      end
      if (commit) txn_live = 0;
      chk("ack", 8'(ack_o), 8'(commit));
      chk("dat", dat_o, exp_d);
      chk("irq", 8'(irq_o), 8'(m_irq));
    end
  end

  // called on a negedge; returns one idle cycle after the ack
  task automatic bus(input logic w, input logic [1:0] a, input logic [7:0] d, output logic [7:0] r);
    int t0;
    bit got;
    got = 0;
    r = 0;
    t0 = cyc_n;
    cyc_i = 1; stb_i = 1; we_i = w; adr_i = a; dat_i = d;
    txn_we = w; txn_adr = a; txn_dat = d; txn_edge = cyc_n + WS + 1; txn_live = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      if (ack_o) begin got = 1; r = dat_o; ack_edge = cyc_n; lat = cyc_n - t0; end
    end
    cyc_i = 0; stb_i = 0;
    if (!got) begin vec++; bad++; $display("FAIL ack timeout: none in 20 cycles, required 1"); end
    @(negedge clk_i);
  endtask

  task automatic wait_irq;
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      if (irq_o) begin got = 1; irq_edge = cyc_n; end
    end
    if (!got) begin vec++; bad++; $display("FAIL irq timeout: irq_o stayed 0, required 1"); end
  endtask

  task automatic cmd_irq(input logic [7:0] c, input logic [7:0] stat, input string nm);
    bus(1, 2'd2, c, q);
    wait_irq();
    chk({nm, " irq latency"}, 8'(irq_edge - ack_edge), 8'(L));
    bus(0, 2'd2, 0, q);
    chk({nm, " status"}, q, stat);
    chk({nm, " irq cleared"}, 8'(irq_o), 8'h00);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    rst_i = 1;
    bus(0, 2'd0, 0, q); chk("reset CSR", q, 8'h00);
    bus(0, 2'd1, 0, q); chk("reset DPR", q, 8'h00);
    bus(0, 2'd2, 0, q); chk("reset CMDR", q, 8'h80);
    bus(0, 2'd3, 0, q); chk("reset FSMR", q, 8'h10);
    chk("reset irq", 8'(irq_o), 8'h00);
    bus(1, 2'd0, 8'hC0, q); chk("CSR write ack latency", 8'(lat), 8'(WS + 1));
    bus(0, 2'd0, 0, q); chk("CSR readback", q, 8'hC0);
    // strobe dropped during WAIT: no ack, CSR untouched
    cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 0; dat_i = 8'h00;
    txn_we = 1; txn_adr = 0; txn_dat = 0; txn_edge = cyc_n + WS + 1; txn_live = 1;
    repeat (2) @(negedge clk_i);
    cyc_i = 0; stb_i = 0; txn_live = 0;
    repeat (3) @(negedge clk_i);
    bus(0, 2'd0, 0, q); chk("abort CSR kept", q, 8'hC0);
    cmd_irq(8'h01, 8'h41, "WRITE no START");
    cmd_irq(8'h07, 8'h17, "cmd 111");
    cmd_irq(8'h04, 8'h84, "START");
    bus(1, 2'd1, 8'h5A, q);
    cmd_irq(8'h01, 8'h81, "WRITE");
    cmd_irq(8'h02, 8'h82, "READ_ACK");
    bus(0, 2'd1, 0, q); chk("DPR loopback", q, 8'h5A);
    // second CMDR write lands on the completion edge while still BUSY
    bus(1, 2'd2, 8'h03, q);
    bus(1, 2'd2, 8'h05, q);
    chk("busy write irq", 8'(irq_o), 8'h01);
    bus(0, 2'd2, 0, q); chk("busy write ignored", q, 8'h83);
    // status read acked on the completion edge
    bus(1, 2'd2, 8'h01, q);
    bus(0, 2'd2, 0, q); chk("read at completion", q, 8'h01);
    chk("set wins irq", 8'(irq_o), 8'h01);
    bus(0, 2'd2, 0, q); chk("post completion", q, 8'h81);
    bus(1, 2'd2, 8'h04, q);
    wait_irq();
    bus(1, 2'd0, 8'h80, q); chk("IE=0 clears irq", 8'(irq_o), 8'h00);
    bus(1, 2'd2, 8'h05, q);
    repeat (L + 2) @(negedge clk_i);
    chk("no irq with IE=0", 8'(irq_o), 8'h00);
    bus(0, 2'd2, 0, q); chk("STOP status", q, 8'h85);
    bus(1, 2'd0, 8'h00, q);
    bus(1, 2'd2, 8'h07, q);
    repeat (L + 3) @(negedge clk_i);
    bus(0, 2'd2, 0, q); chk("E=0 write ignored", q, 8'h85);
    bus(0, 2'd3, 0, q); chk("E=0 FSMR idle", q, 8'h10);
    bus(1, 2'd0, 8'hC0, q);
    bus(1, 2'd2, 8'h04, q);
    @(negedge clk_i);
    #2 rst_i = 0;
    #1 chk("async rst ack", 8'(ack_o), 8'h00);
    chk("async rst irq", 8'(irq_o), 8'h00);
    repeat (2) @(negedge clk_i);
    rst_i = 1;
    bus(0, 2'd3, 0, q); chk("FSMR after reset", q, 8'h10);
    bus(0, 2'd2, 0, q); chk("CMDR after reset", q, 8'h80);
    bus(0, 2'd0, 0, q); chk("CSR after reset", q, 8'h00);
    repeat (L + 2) @(negedge clk_i);
    chk("irq after reset", 8'(irq_o), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
